ll_walker: RTL and testbench

Parametrised linked-list pointer walker, successor to the fixed-table pointer sequence generator in the request-generation path. It holds a runtime-writable next-pointer table and accepts list head pointers over a valid/ready handshake. It emits every node of each list in order on a backpressured output, tagged with position and last-node flags. A length limit terminates cyclic lists, and a mode parameter selects between one idle cycle between lists and back-to-back chaining.

---
 rtl/ll_walker.sv | 126 ++++++++++++
 tb/tb_ll_walker.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ll_walker.sv
// Walks linked lists through a runtime-writable next-pointer table and emits each node in order.
// First node valid one cycle after head acceptance, one node per cycle; outputs hold while out_ptr_rdy_i is low.
module ll_walker #(
    parameter int N       = 256,
    parameter int W_PTR   = $clog2(N),
    parameter int MAX_LEN = N - 1,
    parameter int W_CNT   = $clog2(MAX_LEN),
    parameter int NO_GAP  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [W_PTR-1:0] wr_addr_i,
    input  logic [W_PTR-1:0] wr_data_i,
    input  logic [W_PTR-1:0] start_i,
    input  logic             start_vld_i,
    output logic             start_rdy_o,
    output logic [W_PTR-1:0] out_ptr_o,
    output logic             out_ptr_vld_o,
    input  logic             out_ptr_rdy_i,
    output logic [W_CNT-1:0] out_idx_o,
    output logic             out_last_o,
    output logic             err_loop_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WALK = 1'b1;

    logic [W_PTR-1:0] tbl_q [N];
    logic [0:0]       state_q, state_d;
    logic [W_PTR-1:0] ptr_q, ptr_d;
    logic [W_CNT-1:0] idx_q, idx_d;
    logic             err_q, err_d;

    logic [W_PTR-1:0] nxt;
    logic             vld;
    logic             at_lim;
    logic             last;
    logic             xfer;
    logic             accept;
    logic             head_live;

    // Table reads see the pre-write value in the write cycle, so a write to the
    // current node only affects the walk from the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            tbl_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign vld       = (state_q == S_WALK);
    assign nxt       = tbl_q[ptr_q];
    assign at_lim    = (idx_q == W_CNT'(MAX_LEN - 1));
    assign last      = vld & ((nxt == '0) | at_lim);
    assign xfer      = vld & out_ptr_rdy_i;
    assign head_live = (start_i != '0);

    generate
        if (NO_GAP != 0) begin : g_chain
            assign start_rdy_o = ~vld | (out_ptr_rdy_i & last);
        end else begin : g_gap
            assign start_rdy_o = ~vld;
        end
    endgenerate

    assign accept = start_vld_i & start_rdy_o;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && head_live) begin
                    state_d = S_WALK;
                    ptr_d   = start_i;
                    idx_d   = '0;
                end
            end
            S_WALK: begin
                if (xfer) begin
                    if (!last) begin
                        ptr_d = nxt;
                        idx_d = idx_q + W_CNT'(1);
                    end else begin
                        err_d = at_lim & (nxt != '0);
                        // accept can only be high here when chaining is enabled
                        if (accept && head_live) begin
                            ptr_d = start_i;
                            idx_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign out_ptr_o     = ptr_q;
    assign out_ptr_vld_o = vld;
    assign out_idx_o     = idx_q;
    assign out_last_o    = last;
    assign err_loop_o    = err_q;

endmodule

// File: tb/tb_ll_walker.sv
// Bench for ll_walker: three instances (gap mode, chaining mode, short length limit) share stimulus.
module tb_ll_walker;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] start;
    logic       start_vld;
    logic       out_ptr_rdy;

    logic       srdy0, srdy1, srdy2;
    logic [3:0] ptr0, ptr1, ptr2;
    logic       vld0, vld1, vld2;
    logic [3:0] idx0, idx1;
    logic [2:0] idx2;
    logic       last0, last1, last2;
    logic       err0, err1, err2;

    ll_walker #(.N(16), .MAX_LEN(15), .NO_GAP(0)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .start_i(start), .start_vld_i(start_vld), .start_rdy_o(srdy0),
        .out_ptr_o(ptr0), .out_ptr_vld_o(vld0), .out_ptr_rdy_i(out_ptr_rdy),
        .out_idx_o(idx0), .out_last_o(last0), .err_loop_o(err0));

    ll_walker #(.N(16), .MAX_LEN(15), .NO_GAP(1)) dut_chain (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .start_i(start), .start_vld_i(start_vld), .start_rdy_o(srdy1),
        .out_ptr_o(ptr1), .out_ptr_vld_o(vld1), .out_ptr_rdy_i(out_ptr_rdy),
        .out_idx_o(idx1), .out_last_o(last1), .err_loop_o(err1));

    ll_walker #(.N(16), .MAX_LEN(6), .NO_GAP(0)) dut_lim (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .start_i(start), .start_vld_i(start_vld), .start_rdy_o(srdy2),
        .out_ptr_o(ptr2), .out_ptr_vld_o(vld2), .out_ptr_rdy_i(out_ptr_rdy),
        .out_idx_o(idx2), .out_last_o(last2), .err_loop_o(err2));

    typedef struct {
        logic [3:0] ptr;
        logic [3:0] idx;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_cyc[$];
    int   err_cyc[$];
    int   checks;
    int   errors;
    int   cyc;
    int   sel;

    logic [3:0] m_ptr;
    logic [3:0] m_idx;
    logic       m_vld, m_last, m_err, m_srdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        m_ptr = ptr0; m_idx = idx0; m_vld = vld0; m_last = last0; m_err = err0; m_srdy = srdy0;
        case (sel)
            1: begin m_ptr = ptr1; m_idx = idx1; m_vld = vld1; m_last = last1; m_err = err1; m_srdy = srdy1; end
            2: begin m_ptr = ptr2; m_idx = {1'b0, idx2}; m_vld = vld2; m_last = last2; m_err = err2; m_srdy = srdy2; end
            default: ;
        endcase
    end

    // Scoreboard monitor for the selected instance, sampled on the falling edge.
    logic       prev_stall;
    logic [3:0] prev_ptr, prev_idx;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (m_vld !== 1'b1 || m_ptr !== prev_ptr || m_idx !== prev_idx) begin
                    errors++;
                    $display("FAIL stall_hold: vld=%b ptr=%0d idx=%0d, required vld=1 ptr=%0d idx=%0d",
                             m_vld, m_ptr, m_idx, prev_ptr, prev_idx);
                end
            end
            if (m_vld === 1'b1 && out_ptr_rdy === 1'b1) begin
                xfer_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_xfer: ptr=%0d idx=%0d last=%b, required no transfer", m_ptr, m_idx, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if (m_ptr !== e.ptr || m_idx !== e.idx || m_last !== e.last) begin
                        errors++;
                        $display("FAIL node: ptr=%0d idx=%0d last=%b, required ptr=%0d idx=%0d last=%b",
                                 m_ptr, m_idx, m_last, e.ptr, e.idx, e.last);
                    end
                end
            end
            if (m_err === 1'b1) err_cyc.push_back(cyc);
            prev_stall = (m_vld === 1'b1) && (out_ptr_rdy !== 1'b1);
            prev_ptr   = m_ptr;
            prev_idx   = m_idx;
        end
    end

    task automatic push_exp(input logic [3:0] p, input logic [3:0] i, input logic l);
        exp_t e;
        e.ptr = p; e.idx = i; e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_reset(input int s);
        rst = 1'b1; sel = s; start_vld = 1'b0; wr_en = 1'b0; out_ptr_rdy = 1'b1;
        exp_q.delete(); xfer_cyc.delete(); err_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_head(input logic [3:0] h);
        bit got = 0;
        start = h; start_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_srdy === 1'b1) begin got = 1; break; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL head_accept: head %0d not accepted within 100 cycles", h);
        end else begin
            @(posedge clk); #1;
        end
        start_vld = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        ok = (exp_q.size() == 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; sel = 0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = '0; start_vld = 1'b0; out_ptr_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int ph = 0; ph < 2; ph++) begin
            checks++;
            if ({vld0, vld1, vld2} !== 3'b000 || {last0, last1, last2} !== 3'b000) begin
                errors++; $display("FAIL reset_vld_last ph%0d: vld=%b last=%b, required 000/000", ph, {vld0, vld1, vld2}, {last0, last1, last2});
            end
            checks++;
            if ({ptr0, ptr1, ptr2} !== 12'h000 || {idx0, idx1, idx2} !== 11'h000) begin
                errors++; $display("FAIL reset_ptr_idx ph%0d: ptr=%h idx=%h, required 0", ph, {ptr0, ptr1, ptr2}, {idx0, idx1, idx2});
            end
            checks++;
            if ({err0, err1, err2} !== 3'b000 || {srdy0, srdy1, srdy2} !== 3'b111) begin
                errors++; $display("FAIL reset_err_rdy ph%0d: err=%b start_rdy=%b, required 000/111", ph, {err0, err1, err2}, {srdy0, srdy1, srdy2});
            end
            rst = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_chain;
        bit ok;
        do_reset(0);
        wr(1, 5); wr(5, 3); wr(3, 10); wr(10, 0);
        push_exp(1, 0, 0); push_exp(5, 1, 0); push_exp(3, 2, 0); push_exp(10, 3, 1);
        send_head(1);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL chain_drain: %0d nodes outstanding, required 0", exp_q.size()); end
        checks++;
        if (xfer_cyc.size() != 4 || xfer_cyc[3] - xfer_cyc[0] != 3) begin
            errors++; $display("FAIL chain_consecutive: %0d transfers, required 4 on consecutive cycles", xfer_cyc.size());
        end
        checks++;
        if (err_cyc.size() != 0 || vld0 !== 1'b0) begin
            errors++; $display("FAIL chain_end: err pulses=%0d vld=%b, required 0/0", err_cyc.size(), vld0);
        end
    endtask

    task automatic test_gap(input int mode);
        bit ok;
        int gaps[4];
        gaps = (mode == 0) ? '{1, 1, 2, 1} : '{1, 1, 1, 1};
        do_reset(mode);
        wr(7, 15); wr(15, 8); wr(8, 0); wr(2, 4); wr(4, 0);
        push_exp(7, 0, 0); push_exp(15, 1, 0); push_exp(8, 2, 1);
        push_exp(2, 0, 0); push_exp(4, 1, 1);
        send_head(7);
        send_head(2);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL gap%0d_drain: %0d nodes outstanding, required 0", mode, exp_q.size()); end
        checks++;
        if (xfer_cyc.size() != 5) begin
            errors++; $display("FAIL gap%0d_count: %0d transfers, required 5", mode, xfer_cyc.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                if (xfer_cyc[i] - xfer_cyc[i-1] != gaps[i-1]) begin
                    errors++;
                    $display("FAIL gap%0d_spacing: node %0d spacing %0d, required %0d", mode, i, xfer_cyc[i] - xfer_cyc[i-1], gaps[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        do_reset(0);
        wr(9, 14); wr(14, 11); wr(11, 13); wr(13, 12); wr(12, 0);
        push_exp(9, 0, 0); push_exp(14, 1, 0); push_exp(11, 2, 0); push_exp(13, 3, 0); push_exp(12, 4, 1);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    out_ptr_rdy = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ptr_rdy = 1'b1;
            end
            send_head(9);
        join
        wait_drain(ok);
        checks++;
        if (!ok || xfer_cyc.size() != 5) begin
            errors++; $display("FAIL bp_drain: %0d outstanding, %0d transfers, required 0/5", exp_q.size(), xfer_cyc.size());
        end
        checks++;
        if (err_cyc.size() != 0) begin errors++; $display("FAIL bp_err: %0d err_loop pulses, required 0", err_cyc.size()); end
    endtask

    task automatic test_loop;
        bit ok;
        do_reset(2);
        wr(4, 9); wr(9, 4);
        for (int i = 0; i < 6; i++) push_exp((i % 2 == 0) ? 4'd4 : 4'd9, 4'(i), i == 5);
        send_head(4);
        wait_drain(ok);
        checks++;
        if (!ok || xfer_cyc.size() != 6) begin
            errors++; $display("FAIL loop_drain: %0d outstanding, %0d transfers, required 0/6", exp_q.size(), xfer_cyc.size());
        end
        checks++;
        if (err_cyc.size() != 1 || (xfer_cyc.size() == 6 && err_cyc[0] != xfer_cyc[5] + 1)) begin
            errors++; $display("FAIL loop_err: %0d pulses, required exactly 1 in the cycle after the 6th node", err_cyc.size());
        end
        checks++;
        if (vld2 !== 1'b0 || srdy2 !== 1'b1) begin
            errors++; $display("FAIL loop_idle: vld=%b start_rdy=%b, required 0/1", vld2, srdy2);
        end
    endtask

    task automatic test_null_live;
        bit ok;
        do_reset(0);
        send_head(0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (xfer_cyc.size() != 0 || vld0 !== 1'b0 || srdy0 !== 1'b1 || err_cyc.size() != 0) begin
            errors++; $display("FAIL null_head: transfers=%0d vld=%b start_rdy=%b err=%0d, required 0/0/1/0",
                               xfer_cyc.size(), vld0, srdy0, err_cyc.size());
        end
        wr(1, 5); wr(5, 3);
        // write lands on the handshake edge: walk still sees the old successor
        push_exp(1, 0, 0); push_exp(5, 1, 0); push_exp(3, 2, 1);
        send_head(1);
        @(posedge clk); #1;
        checks++;
        if (ptr0 !== 4'd5) begin errors++; $display("FAIL live_same_pos: ptr=%0d, required 5", ptr0); end
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'd6;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL live_same_drain: %0d outstanding, required 0", exp_q.size()); end
        // write lands one edge before the handshake: new successor is taken
        wr(5, 3);
        push_exp(1, 0, 0); push_exp(5, 1, 0); push_exp(6, 2, 1);
        send_head(1);
        @(posedge clk); #1;
        checks++;
        if (ptr0 !== 4'd5) begin errors++; $display("FAIL live_early_pos: ptr=%0d, required 5", ptr0); end
        out_ptr_rdy = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 4'd6;
        @(posedge clk); #1;
        wr_en = 1'b0;
        out_ptr_rdy = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL live_early_drain: %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset(0);
        wr(1, 5); wr(5, 3); wr(3, 10);
        push_exp(1, 0, 0); push_exp(5, 1, 0);
        send_head(1);
        repeat (2) @(posedge clk);
        #1;
        out_ptr_rdy = 1'b0;
        checks++;
        if (idx0 !== 4'd2 || ptr0 !== 4'd3) begin errors++; $display("FAIL rmid_pos: ptr=%0d idx=%0d, required 3/2", ptr0, idx0); end
        rst = 1'b1;
        #1;
        checks++;
        if (vld0 !== 1'b0 || srdy0 !== 1'b1 || ptr0 !== 4'd0 || idx0 !== 4'd0 || last0 !== 1'b0) begin
            errors++; $display("FAIL rmid_clear: vld=%b rdy=%b ptr=%0d idx=%0d last=%b, required 0/1/0/0/0",
                               vld0, srdy0, ptr0, idx0, last0);
        end
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ptr_rdy = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_pre: %0d outstanding, required 0", exp_q.size()); end
        push_exp(1, 0, 1); push_exp(5, 0, 1);
        send_head(1);
        send_head(5);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_single: %0d outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; prev_stall = 1'b0;
        test_reset();
        test_chain();
        test_gap(0);
        test_gap(1);
        test_backpressure();
        test_loop();
        test_null_live();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
